// File: rtl/vm2002_change_dispenser_if.sv
// Signal bundle between the vm2002 core/supplier side and the change dispenser.
// The dispenser takes the slave view; the driving environment takes the master view.
interface vm2002_change_dispenser_if;
    logic [1:0]  status;
    logic [15:0] balance;
    logic        load_valid;
    logic [1:0]  load_coin;
    logic [3:0]  load_count;
    logic [1:0]  coin_out;
    logic        coin_valid;
    logic        busy;
    logic        done;
    logic        shortfall;
    logic [15:0] residual;
    logic [7:0]  q_cnt;
    logic [7:0]  d_cnt;
    logic [7:0]  n_cnt;

    modport master (
        output status, balance, load_valid, load_coin, load_count,
        input  coin_out, coin_valid, busy, done, shortfall, residual, q_cnt, d_cnt, n_cnt
    );

    modport slave (
        input  status, balance, load_valid, load_coin, load_count,
        output coin_out, coin_valid, busy, done, shortfall, residual, q_cnt, d_cnt, n_cnt
    );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// Change-return engine: on a refund edge, pays the balance back greedily as a
// paced coin stream drawn from saturating per-denomination inventory counters.
module vm2002_change_dispenser #(
    parameter logic [1:0]  REFUND_CODE = 2'b11,
    parameter int unsigned COIN_GAP    = 2,
    parameter int unsigned INIT_COUNT  = 0
) (
    input logic                      clk,
    input logic                      hrst,
    vm2002_change_dispenser_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PAY, S_GAP} state_t;

    localparam logic [7:0]  INIT_Q   = 8'(INIT_COUNT);
    localparam logic [15:0] GAP_LOAD = 16'((COIN_GAP >= 2) ? COIN_GAP - 2 : 0);

    state_t      state_q;
    logic [1:0]  prev_status_q;
    logic [15:0] rem_q;
    logic [15:0] gap_q;
    logic [1:0]  coin_out_q;
    logic        coin_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        shortfall_q;
    logic [15:0] residual_q;

    logic [7:0]  inv_cnt [1:3];
    logic        trigger;
    logic [1:0]  sel_coin;
    logic [15:0] sel_val;

    assign trigger = (bus.status == REFUND_CODE) && (prev_status_q != REFUND_CODE);

    // Greedy pick; index 3/2/1 = quarter/dime/nickel, same as the coin encoding.
    always_comb begin
        sel_coin = 2'b00;
        sel_val  = 16'd0;
        if (rem_q >= 16'd25 && inv_cnt[3] != 8'd0) begin
            sel_coin = 2'b11;
            sel_val  = 16'd25;
        end else if (rem_q >= 16'd10 && inv_cnt[2] != 8'd0) begin
            sel_coin = 2'b10;
            sel_val  = 16'd10;
        end else if (rem_q >= 16'd5 && inv_cnt[1] != 8'd0) begin
            sel_coin = 2'b01;
            sel_val  = 16'd5;
        end
    end

    generate
        for (genvar gi = 1; gi <= 3; gi++) begin : g_inv
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;
            logic [9:0] sum;
            logic       load_hit;
            logic       disp_hit;

            // A coin is only ever dispensed when cnt_q > 0, so the subtraction cannot wrap.
            always_comb begin
                load_hit = bus.load_valid && (bus.load_coin == 2'(gi));
                disp_hit = (state_q == S_PAY) && (sel_coin == 2'(gi));
                sum      = {2'b00, cnt_q}
                         + (load_hit ? {6'b0, bus.load_count} : 10'd0)
                         - (disp_hit ? 10'd1 : 10'd0);
                cnt_d    = (sum > 10'd255) ? 8'hFF : sum[7:0];
            end

            always_ff @(posedge clk) begin
                if (hrst) begin
                    cnt_q <= INIT_Q;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign inv_cnt[gi] = cnt_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (hrst) begin
            state_q       <= S_IDLE;
            prev_status_q <= 2'b00;
            rem_q         <= 16'd0;
            gap_q         <= 16'd0;
            coin_out_q    <= 2'b00;
            coin_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            shortfall_q   <= 1'b0;
            residual_q    <= 16'd0;
        end else begin
            prev_status_q <= bus.status;
            coin_out_q    <= 2'b00;
            coin_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        rem_q       <= bus.balance;
                        shortfall_q <= 1'b0;
                        residual_q  <= 16'd0;
                        busy_q      <= 1'b1;
                        state_q     <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (sel_coin != 2'b00) begin
                        coin_out_q   <= sel_coin;
                        coin_valid_q <= 1'b1;
                        rem_q        <= rem_q - sel_val;
                        if (COIN_GAP >= 2) begin
                            gap_q   <= GAP_LOAD;
                            state_q <= S_GAP;
                        end
                    end else begin
                        done_q      <= 1'b1;
                        shortfall_q <= (rem_q != 16'd0);
                        residual_q  <= rem_q;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_q == 16'd0) begin
                        state_q <= S_PAY;
                    end else begin
                        gap_q <= gap_q - 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.coin_out   = coin_out_q;
    assign bus.coin_valid = coin_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.shortfall  = shortfall_q;
    assign bus.residual   = residual_q;
    assign bus.q_cnt      = inv_cnt[3];
    assign bus.d_cnt      = inv_cnt[2];
    assign bus.n_cnt      = inv_cnt[1];
endmodule
